comm_txgen: RTL and testbench
=============================

# comm_txgen

Parametrised multi-channel half-duplex frame transmitter for the comm board's line drivers. It replaces free-running clock outputs and hard-tied transmit enables on the A..D style ports with real framed transmission. Each start request sends one UART-style frame, at a programmable bit rate, on every channel selected by a mask. The driver enable is framed by lead/trail guard intervals. An optional loopback checker compares each channel's receiver against the transmitted bits; it sits between the SPI control register and the transceiver pins.

## Interface
- CHANNELS, 4: number of line channels.
- DATA_W, 8: data bits per frame.
- DIV_W, 16: width of bit-period divider.
- GUARD, 2: lead and trail guard length, in bit times (≥1).

- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- div_i  in  DIV_W  bit period minus one, in clk_i cycles; latched at start.
- mask_i  in  CHANNELS  channels to transmit on; latched at start.
- data_i  in  DATA_W  frame payload; latched at start.
- start_i  in  1  one-cycle request.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at end of frame.
- txd_o  out  CHANNELS  line data, idle high.
- txen_o  out  CHANNELS  driver enable per channel.
- rxd_i  in  CHANNELS  line receiver inputs, used only for loopback.
- err_o  out  CHANNELS  sticky loopback mismatch flags.

## Operation
- The single FSM has states IDLE, LEAD, START, DATA, STOP and TRAIL. One shared bit timer and one bit index serve all channels, so every selected channel transmits the identical frame in lockstep.
- IDLE: `start_i` latches `div_i`, `mask_i` and `data_i`, and clears `err_o`.
  - If the latched mask is non-zero, the FSM goes to LEAD.
  - If the mask is zero, the FSM stays in IDLE and pulses `done_o` on the next cycle.
- LEAD: lasts GUARD bit times. `txen_o` equals the mask and `txd_o` is 1.
- START: lasts one bit time. `txd_o` is 0 on masked channels.
- DATA: lasts DATA_W bit times, sending `data` LSB first.
- STOP: lasts one bit time. `txd_o` is 1.
- TRAIL: lasts GUARD bit times. `txd_o` is 1 and `txen_o` stays equal to the mask. TRAIL then returns to IDLE.
- Unmasked channels always hold `txd_o`=1 and `txen_o`=0.
- Bit timer: loads the latched divider at each bit boundary, counts down to 0, then advances. One bit lasts div+1 cycles, and div=0 gives a bit every cycle. Width is DIV_W with no wrap: the timer is reloaded, never decremented below 0.
- `start_i` while `busy_o`=1 is ignored. No queueing is done, and the latched values and `err_o` are unchanged.
- Reset asserted mid-frame aborts immediately to IDLE with all outputs at their reset values. No trail is sent.

## Timing
- Reset values: `txd_o` all 1s; `txen_o`, `busy_o`, `done_o` and `err_o` all 0.
- Start latency: `start_i` sampled high at edge N gives `txen_o` and `busy_o` high from edge N+1.
- Frame length: `txen_o` is high for exactly (2·GUARD + DATA_W + 2)·(div+1) cycles.
- End of frame: on the first cycle after TRAIL, `txen_o` and `busy_o` are low and `done_o` is high for one cycle. A `start_i` in that same cycle is accepted.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- COMM_TXGEN_LOOPBACK_EN defined:
  - During START, DATA and STOP, each masked channel's `rxd_i` (synchronised through 2 flops inside the block) is sampled when the bit timer equals div>>1.
  - Sampling is compensated for the 2-cycle synchroniser delay: the synchronised value is compared against the bit driven 2 cycles earlier.
  - A mismatch sets that channel's `err_o` bit. The flag stays set until the next accepted start or reset.
- Not defined: `rxd_i` is unused, no synchroniser is built, and `err_o` is constant 0.

## Test plan
- Reset state: assert `rst_n_i`=0 mid-frame → all outputs return to their reset values asynchronously; after release the block sits in IDLE.
- Basic frame:
  - Stimulus: CHANNELS=4, GUARD=2, div=3, mask=0101, data=0xA5, one-cycle start.
  - Response: `txen_o`=0101 for 56 cycles; `txd_o`[0] shows 8 high cycles, then 4 low for the start bit, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 high for stop and 8 high for trail. Channels 1 and 3 stay at txd=1, txen=0, and `done_o` pulses once.
- Zero mask and busy start: start with mask=0 → `done_o` pulses the next cycle and `txen_o` stays 0. A second start issued 10 cycles into a frame → no effect on the output waveform.
- Minimum divider: div=0, data=0xFF, mask=1111 → `txen_o` high for 14 cycles and a single-cycle start bit low.
- Back-to-back: start asserted in the `done_o` cycle → next frame's `txen_o` rises on the following edge.
- Loopback (with COMM_TXGEN_LOOPBACK_EN): `rxd_i`=`txd_o` on channel 0, and channel 1 forced to 1 while mask=0011 and data=0x00 → `err_o`=0010 after the frame; next start clears it to 0000.

Source files
------------

// File: rtl/comm_txgen_if.sv
// comm_txgen_if: control and line bundle for comm_txgen.
//   master : controller/line side (drives div/mask/data/start and rxd)
//   slave  : transmitter side (drives busy/done/txd/txen/err)
interface comm_txgen_if #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 16
);
  logic [DIV_W-1:0]    div_i;
  logic [CHANNELS-1:0] mask_i;
  logic [DATA_W-1:0]   data_i;
  logic                start_i;
  logic                busy_o;
  logic                done_o;
  logic [CHANNELS-1:0] txd_o;
  logic [CHANNELS-1:0] txen_o;
  logic [CHANNELS-1:0] rxd_i;
  logic [CHANNELS-1:0] err_o;

  modport master (
    output div_i, mask_i, data_i, start_i, rxd_i,
    input  busy_o, done_o, txd_o, txen_o, err_o
  );

  modport slave (
    input  div_i, mask_i, data_i, start_i, rxd_i,
    output busy_o, done_o, txd_o, txen_o, err_o
  );
endinterface

// File: rtl/comm_txgen.sv
// comm_txgen: multi-channel half-duplex UART-style frame transmitter.
// One start request sends a guarded frame (lead guard, start bit, DATA_W
// data bits LSB first, stop bit, trail guard) on every masked channel in
// lockstep, at a bit period of div+1 clk_i cycles.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus (slave)    : div/mask/data/start in, busy/done/txd/txen/err out,
//                    rxd in (loopback receivers)
// Optional feature: define COMM_TXGEN_LOOPBACK_EN to build the loopback
// checker; otherwise rxd_i is ignored and err_o is tied to 0.
module comm_txgen #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 16,
  parameter int GUARD    = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  comm_txgen_if.slave  bus
);

  localparam int CNT_MAX = (DATA_W > GUARD) ? DATA_W : GUARD;
  localparam int IDX_W   = $clog2(CNT_MAX) + 1;
  localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD - 1);
  localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, START, DATA, STOP, TRAIL} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    timer_q, timer_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CHANNELS-1:0] txd_q, txd_d;
  logic [CHANNELS-1:0] txen_q, txen_d;
  logic [DATA_W-1:0]   data_sh;
  logic                line_bit;

  // Outputs are registered by computing them from the next-state values,
  // so they change on the same edge as the state they describe.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    div_d    = div_q;
    mask_d   = mask_q;
    data_d   = data_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    data_sh  = '0;
    line_bit = 1'b1;

    if (state_q == IDLE) begin
      if (bus.start_i) begin
        div_d   = bus.div_i;
        mask_d  = bus.mask_i;
        data_d  = bus.data_i;
        timer_d = bus.div_i;
        idx_d   = '0;
        if (bus.mask_i != '0) state_d = LEAD;
        else                  done_d  = 1'b1;
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - DIV_W'(1);
    end else begin
      timer_d = div_q;
      unique case (state_q)
        LEAD: begin
          if (idx_q == GUARD_LAST) begin
            state_d = START;
            idx_d   = '0;
          end else idx_d = idx_q + IDX_W'(1);
        end
        START: begin
          state_d = DATA;
          idx_d   = '0;
        end
        DATA: begin
          if (idx_q == DATA_LAST) begin
            state_d = STOP;
            idx_d   = '0;
          end else idx_d = idx_q + IDX_W'(1);
        end
        STOP: begin
          state_d = TRAIL;
          idx_d   = '0;
        end
        TRAIL: begin
          if (idx_q == GUARD_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else idx_d = idx_q + IDX_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    txen_d = busy_d ? mask_d : '0;
    unique case (state_d)
      START:   line_bit = 1'b0;
      DATA: begin
        data_sh  = data_d >> idx_d;
        line_bit = data_sh[0];
      end
      default: line_bit = 1'b1;
    endcase
    // Unmasked channels have txen=0 and therefore idle high.
    txd_d = line_bit ? '1 : ~txen_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txd_q   <= '1;
      txen_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.txd_o  = txd_q;
  assign bus.txen_o = txen_q;

`ifdef COMM_TXGEN_LOOPBACK_EN
  logic [CHANNELS-1:0] rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [CHANNELS-1:0] tx_h1_q, tx_h1_d, tx_h2_q, tx_h2_d;
  logic [CHANNELS-1:0] err_q, err_d;
  logic                start_acc;

  assign start_acc = (state_q == IDLE) && bus.start_i;

  // rx_s2 lags the line by two cycles; tx_h2 delays the driven bits by the
  // same amount so both sides of the compare refer to the same cycle.
  always_comb begin
    rx_s1_d = bus.rxd_i;
    rx_s2_d = rx_s1_q;
    tx_h1_d = txd_q;
    tx_h2_d = tx_h1_q;
    err_d   = err_q;
    if (start_acc) begin
      err_d = '0;
    end else if ((state_q inside {START, DATA, STOP}) &&
                 (timer_q == (div_q >> 1))) begin
      err_d = err_q | (mask_q & (rx_s2_q ^ tx_h2_q));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_s1_q <= '1;
      rx_s2_q <= '1;
      tx_h1_q <= '1;
      tx_h2_q <= '1;
      err_q   <= '0;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      tx_h1_q <= tx_h1_d;
      tx_h2_q <= tx_h2_d;
      err_q   <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  logic unused_rxd;
  assign unused_rxd = ^bus.rxd_i;
  assign bus.err_o  = '0;
`endif

endmodule

// File: tb/tb_comm_txgen.sv
// tb_comm_txgen: self-checking bench for comm_txgen (CHANNELS=4, DATA_W=8,
// DIV_W=16, GUARD=2). Table-driven frame measurements, waveform checks
// against a frame-bit-list reference model, and hand-written corner cases.
module tb_comm_txgen;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam int GD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] rx_f1 = '0;
  logic [CH-1:0] rx_f0 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  comm_txgen_if #(.CHANNELS(CH), .DATA_W(DW), .DIV_W(16)) bus ();

  comm_txgen #(.CHANNELS(CH), .DATA_W(DW), .DIV_W(16), .GUARD(GD)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Line loopback: receivers see the driven line unless forced.
  assign bus.rxd_i = (bus.txd_o | rx_f1) & ~rx_f0;

  typedef struct {
    logic [15:0] div;
    logic [3:0]  mask;
    logic [7:0]  data;
    int          len;
    int          low0;
    int          low3;
    int          dones;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a frame and counts txen cycles, low cycles on ch0/ch3 and done
  // pulses until a few cycles past the first done.
  task automatic measure(input vec_t v);
    int len, low0, low3, dn, tail;
    bit seen;
    len = 0; low0 = 0; low3 = 0; dn = 0; tail = 0; seen = 0;
    bus.div_i = v.div; bus.mask_i = v.mask; bus.data_i = v.data; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (bus.txen_o != '0) len++;
      if (!bus.txd_o[0]) low0++;
      if (!bus.txd_o[3]) low3++;
      if (bus.done_o) begin dn++; seen = 1; end
      if (seen) tail++;
      @(negedge clk);
      if (tail == 4) break;
    end
    check("tbl_done_seen", 32'(seen), 32'd1);
    check($sformatf("tbl_len div%0d m%0h", v.div, v.mask), 32'(len), 32'(v.len));
    check($sformatf("tbl_low0 d%0h", v.data), 32'(low0), 32'(v.low0));
    check($sformatf("tbl_low3 d%0h", v.data), 32'(low3), 32'(v.low3));
    check("tbl_dones", 32'(dn), 32'(v.dones));
  endtask

  // Reference: the frame is a list of line bits, each held div+1 cycles.
  task automatic check_frame(input logic [15:0] dv, input logic [3:0] mk,
                             input logic [7:0] dt, input bit poke,
                             input logic [3:0] exp_err);
    int bits[$];
    int per, len;
    logic [3:0] exp_txd;
    bits = {};
    for (int g = 0; g < GD; g++) bits.push_back(1);
    bits.push_back(0);
    for (int i = 0; i < DW; i++) bits.push_back(int'(dt[i]));
    bits.push_back(1);
    for (int g = 0; g < GD; g++) bits.push_back(1);
    per = int'(dv) + 1;
    len = bits.size() * per;
    bus.div_i = dv; bus.mask_i = mk; bus.data_i = dt; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("err_cleared", 32'(bus.err_o), 32'd0);
    for (int c = 0; c < len; c++) begin
      exp_txd = (bits[c / per] != 0) ? 4'hF : ~mk;
      check($sformatf("frame d%0h m%0h div%0d cyc%0d {busy,done,txen,txd}", dt, mk, dv, c),
            32'({bus.busy_o, bus.done_o, bus.txen_o, bus.txd_o}),
            32'({1'b1, 1'b0, mk, exp_txd}));
      if (poke && c == 10) begin
        bus.start_i = 1'b1; bus.mask_i = ~mk; bus.data_i = ~dt; bus.div_i = dv + 16'd1;
      end else if (poke && c == 11) begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
    end
    check("frame_end {busy,done,txen,txd}",
          32'({bus.busy_o, bus.done_o, bus.txen_o, bus.txd_o}),
          32'({1'b0, 1'b1, 4'h0, 4'hF}));
    check("frame_err", 32'(bus.err_o), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdv;
    logic [3:0]  rmk;
    logic [7:0]  rdt;

    vecs[0] = '{div: 16'd3, mask: 4'b0101, data: 8'hA5, len: 56, low0: 20, low3: 0, dones: 1};
    vecs[1] = '{div: 16'd0, mask: 4'b1111, data: 8'hFF, len: 14, low0: 1,  low3: 1, dones: 1};
    vecs[2] = '{div: 16'd0, mask: 4'b0001, data: 8'h00, len: 14, low0: 9,  low3: 0, dones: 1};
    vecs[3] = '{div: 16'd1, mask: 4'b1000, data: 8'h0F, len: 28, low0: 0,  low3: 10, dones: 1};
    vecs[4] = '{div: 16'd2, mask: 4'b0000, data: 8'h5A, len: 0,  low0: 0,  low3: 0, dones: 1};

    bus.div_i = '0; bus.mask_i = '0; bus.data_i = '0; bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset {busy,done,txen,txd,err}",
          32'({bus.busy_o, bus.done_o, bus.txen_o, bus.txd_o, bus.err_o}),
          32'({1'b0, 1'b0, 4'h0, 4'hF, 4'h0}));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) measure(vecs[i]);

    // Basic frame, exact waveform.
    check_frame(16'd3, 4'b0101, 8'hA5, 1'b0, 4'h0);
    @(negedge clk);

    // Zero mask: done next cycle, no enable.
    bus.mask_i = '0; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("zmask {busy,done,txen}", 32'({bus.busy_o, bus.done_o, bus.txen_o}), 32'({1'b0, 1'b1, 4'h0}));
    @(negedge clk);
    check("zmask_after {busy,done,txen}", 32'({bus.busy_o, bus.done_o, bus.txen_o}), 32'd0);

    // Start while busy is ignored.
    check_frame(16'd3, 4'b0110, 8'h3C, 1'b1, 4'h0);
    @(negedge clk);

    // Minimum divider.
    check_frame(16'd0, 4'b1111, 8'hFF, 1'b0, 4'h0);
    @(negedge clk);

    // Back-to-back: next start issued in the done cycle.
    check_frame(16'd2, 4'b0011, 8'h3C, 1'b0, 4'h0);
    check_frame(16'd1, 4'b1100, 8'h81, 1'b0, 4'h0);
    @(negedge clk);

    // Randomised frames against the reference model.
    for (int k = 0; k < 12; k++) begin
      rdv = 16'($urandom_range(0, 4));
      rmk = 4'($urandom_range(1, 15));
      rdt = 8'($urandom);
      check_frame(rdv, rmk, rdt, 1'b0, 4'h0);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);

    // Asynchronous reset mid-frame.
    bus.div_i = 16'd3; bus.mask_i = 4'hF; bus.data_i = 8'h55; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset {busy,done,txen,txd,err}",
          32'({bus.busy_o, bus.done_o, bus.txen_o, bus.txd_o, bus.err_o}),
          32'({1'b0, 1'b0, 4'h0, 4'hF, 4'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle {busy,done,txen,txd}",
          32'({bus.busy_o, bus.done_o, bus.txen_o, bus.txd_o}),
          32'({1'b0, 1'b0, 4'h0, 4'hF}));
    check_frame(16'd1, 4'b1001, 8'hC3, 1'b0, 4'h0);
    @(negedge clk);

`ifdef COMM_TXGEN_LOOPBACK_EN
    // Channel 1 receiver stuck high while sending zeros.
    rx_f1 = 4'b0010;
    check_frame(16'd3, 4'b0011, 8'h00, 1'b0, 4'b0010);
    @(negedge clk);
    check("lb_sticky", 32'(bus.err_o), 32'h2);
    rx_f1 = '0;
    check_frame(16'd3, 4'b0011, 8'h00, 1'b0, 4'b0000);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
